regfile_writeback: RTL and testbench

//  Write end of the 8-bit register datapath: owns the register array, performs all

---
 rtl/regfile_writeback.sv | 138 +++++++++++++
 tb/tb_regfile_writeback.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//   Write end of the 8-bit register datapath. Owns the register array, performs
//   every register write (ALU result, or memory load data returned through a
//   valid handshake) and serves the two combinational read ports feeding the
//   ALU source muxes. While a load is outstanding, Stall is raised to freeze the
//   PC; a load that never returns is abandoned after LOAD_TMO cycles and flags
//   the sticky LoadErr. Register 0 is hardwired to zero.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   ReadReg1/2 -> ReadData1/2  combinational read ports (reg 0 reads 0)
//   zero_register              constant zero
//   RegWrite, MemtoReg,        write request; MemtoReg=1 selects a load
//   WriteReg, ALUResult        destination and ALU write data
//   MemValid, MemReadData      load data strobe and data from data memory
//   Stall                      high while a load is outstanding
//   LoadErr                    sticky load-timeout flag
// -----------------------------------------------------------------------------
module regfile_writeback #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int LOAD_TMO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] zero_register,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              MemValid,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              Stall,
  output logic              LoadErr
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  // The last waiting cycle is the one in which the counter would reach LOAD_TMO.
  localparam logic [3:0] TMO_LAST = 4'(LOAD_TMO - 1);

  logic [DATA_W-1:0] regs [NUM_REGS];

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pendDst, pendDstNext;
  logic [3:0]        count, countNext;
  logic              errSet;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;

  // State, pending destination, timeout counter and sticky error flag.
  // Reset mid-load simply drops the pending load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pendDst <= '0;
      count   <= '0;
      LoadErr <= 1'b0;
    end else begin
      state   <= stateNext;
      pendDst <= pendDstNext;
      count   <= countNext;
      if (errSet) begin
        LoadErr <= 1'b1;
      end
    end
  end

  // Next-state and write-port selection. In IDLE a load whose data is already
  // valid in the request cycle is written straight away without stalling.
  // In WAIT_MEM all upstream write inputs are ignored; MemValid beats the
  // timeout when both happen in the same cycle.
  always_comb begin
    stateNext   = state;
    pendDstNext = pendDst;
    countNext   = count;
    errSet      = 1'b0;
    wrEn        = 1'b0;
    wrAddr      = WriteReg;
    wrData      = ALUResult;
    unique case (state)
      IDLE: begin
        if (RegWrite) begin
          if (!MemtoReg) begin
            wrEn = 1'b1;
          end else if (MemValid) begin
            wrEn   = 1'b1;
            wrData = MemReadData;
          end else begin
            stateNext   = WAIT_MEM;
            pendDstNext = WriteReg;
            countNext   = '0;
          end
        end
      end
      WAIT_MEM: begin
        wrAddr = pendDst;
        wrData = MemReadData;
        if (MemValid) begin
          wrEn      = 1'b1;
          stateNext = IDLE;
        end else if (count == TMO_LAST) begin
          stateNext = IDLE;
          countNext = '0;
          errSet    = 1'b1;
        end else begin
          countNext = count + 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Register array. Register 0 is never written, so it stays at its reset zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn && (wrAddr != '0)) begin
      regs[wrAddr] <= wrData;
    end
  end

  // Reads have no bypass: a write becomes visible only after its clock edge.
  assign ReadData1     = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
  assign ReadData2     = (ReadReg2 == '0) ? '0 : regs[ReadReg2];
  assign zero_register = '0;
  assign Stall         = (state == WAIT_MEM);

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
//   Self-checking bench for regfile_writeback. A behavioural reference model
//   (plain register array plus a "load in flight" record) predicts every
//   output; directed sequences cover reset, ALU writes, register 0, stalled
//   loads, timeouts and same-cycle loads, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;

  logic       clk;
  logic       reset;
  logic [2:0] ReadReg1, ReadReg2;
  logic [7:0] ReadData1, ReadData2, zero_register;
  logic       RegWrite, MemtoReg;
  logic [2:0] WriteReg;
  logic [7:0] ALUResult;
  logic       MemValid;
  logic [7:0] MemReadData;
  logic       Stall, LoadErr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] modelRegs [8];
  bit         loadBusy;
  int         loadWaited;
  logic [2:0] loadDst;
  bit         modelErr;

  regfile_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .ReadReg1     (ReadReg1),
    .ReadReg2     (ReadReg2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .zero_register(zero_register),
    .RegWrite     (RegWrite),
    .MemtoReg     (MemtoReg),
    .WriteReg     (WriteReg),
    .ALUResult    (ALUResult),
    .MemValid     (MemValid),
    .MemReadData  (MemReadData),
    .Stall        (Stall),
    .LoadErr      (LoadErr)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < 8; i++) modelRegs[i] = 8'h00;
    loadBusy   = 0;
    loadWaited = 0;
    loadDst    = 3'd0;
    modelErr   = 0;
  endfunction

  function automatic void modelWrite(input logic [2:0] a, input logic [7:0] d);
    if (a != 3'd0) modelRegs[a] = d;
  endfunction

  // Effect of one clock edge, given the inputs held during the cycle before it.
  function automatic void modelEdge(input logic rw, input logic mtr, input logic [2:0] wr,
                                    input logic [7:0] alu, input logic mv, input logic [7:0] md);
    if (!loadBusy) begin
      if (rw && !mtr)      modelWrite(wr, alu);
      else if (rw && mv)   modelWrite(wr, md);
      else if (rw) begin
        loadBusy   = 1;
        loadDst    = wr;
        loadWaited = 0;
      end
    end else begin
      loadWaited++;
      if (mv) begin
        modelWrite(loadDst, md);
        loadBusy = 0;
      end else if (loadWaited == 15) begin
        loadBusy = 0;
        modelErr = 1;
      end
    end
  endfunction

  task automatic checkVisible(input string tag);
    checkOutput({tag, ".rd1"}, ReadData1, modelRegs[ReadReg1]);
    checkOutput({tag, ".rd2"}, ReadData2, modelRegs[ReadReg2]);
    checkOutput({tag, ".zero"}, zero_register, 8'h00);
    checkOutput({tag, ".stall"}, Stall, loadBusy);
    checkOutput({tag, ".loaderr"}, LoadErr, modelErr);
  endtask

  // Drives one cycle of inputs (called just after a falling edge), checks the
  // combinational outputs, then advances the model across the rising edge.
  task automatic applyStimulus(input string tag, input logic rw, input logic mtr,
                               input logic [2:0] wr, input logic [7:0] alu,
                               input logic mv, input logic [7:0] md,
                               input logic [2:0] r1, input logic [2:0] r2);
    RegWrite    = rw;
    MemtoReg    = mtr;
    WriteReg    = wr;
    ALUResult   = alu;
    MemValid    = mv;
    MemReadData = md;
    ReadReg1    = r1;
    ReadReg2    = r2;
    #1;
    checkVisible(tag);
    @(posedge clk);
    modelEdge(rw, mtr, wr, alu, mv, md);
    @(negedge clk);
  endtask

  task automatic idleCycle(input string tag, input logic [2:0] r1, input logic [2:0] r2);
    applyStimulus(tag, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, r1, r2);
  endtask

  // Asynchronous reset: outputs must clear immediately, before any edge.
  task automatic doReset();
    reset = 1'b1;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    MemValid = 1'b0;
    modelClear();
    for (int i = 0; i < 8; i += 2) begin
      ReadReg1 = 3'(i);
      ReadReg2 = 3'(i + 1);
      #1;
      checkVisible("reset");
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    RegWrite = 1'b0; MemtoReg = 1'b0; WriteReg = 3'd0; ALUResult = 8'h00;
    MemValid = 1'b0; MemReadData = 8'h00; ReadReg1 = 3'd0; ReadReg2 = 3'd0;
    #2;
    doReset();

    // ALU write to reg3: 00 before the edge, A5 after it
    applyStimulus("alu3", 1, 0, 3'd3, 8'hA5, 0, 8'h00, 3'd3, 3'd3);
    idleCycle("alu3.after", 3'd3, 3'd0);
    checkOutput("alu3.value", ReadData1, 8'hA5);

    // Write to reg0 is dropped
    applyStimulus("reg0", 1, 0, 3'd0, 8'hFF, 0, 8'h00, 3'd0, 3'd0);
    idleCycle("reg0.after", 3'd0, 3'd3);
    checkOutput("reg0.value", ReadData1, 8'h00);

    // Load to reg5, data after 3 cycles; RegWrite to reg6 during stall ignored
    applyStimulus("ld5.req", 1, 1, 3'd5, 8'h00, 0, 8'h00, 3'd5, 3'd6);
    applyStimulus("ld5.w1", 1, 0, 3'd6, 8'h99, 0, 8'h00, 3'd5, 3'd6);
    applyStimulus("ld5.w2", 1, 0, 3'd6, 8'h98, 0, 8'h00, 3'd5, 3'd6);
    applyStimulus("ld5.w3", 1, 0, 3'd6, 8'h97, 1, 8'h3C, 3'd5, 3'd6);
    idleCycle("ld5.done", 3'd5, 3'd6);
    checkOutput("ld5.value", ReadData1, 8'h3C);
    checkOutput("ld5.reg6", ReadData2, 8'h00);

    // Load timeout on reg2 (preloaded with 11); late MemValid ignored
    applyStimulus("tmo.pre", 1, 0, 3'd2, 8'h11, 0, 8'h00, 3'd2, 3'd0);
    applyStimulus("tmo.req", 1, 1, 3'd2, 8'h00, 0, 8'h00, 3'd2, 3'd0);
    for (int i = 0; i < 15; i++) idleCycle("tmo.wait", 3'd2, 3'd0);
    applyStimulus("tmo.late", 0, 0, 3'd0, 8'h00, 1, 8'hEE, 3'd2, 3'd0);
    idleCycle("tmo.after", 3'd2, 3'd0);
    checkOutput("tmo.reg2", ReadData1, 8'h11);
    checkOutput("tmo.err", LoadErr, 1'b1);

    // Load satisfied in the request cycle: no stall
    applyStimulus("ld4.same", 1, 1, 3'd4, 8'h00, 1, 8'h7E, 3'd4, 3'd0);
    idleCycle("ld4.after", 3'd4, 3'd0);
    checkOutput("ld4.value", ReadData1, 8'h7E);
    checkOutput("ld4.stall", Stall, 1'b0);

    // Reset in the middle of a load discards it and clears LoadErr
    applyStimulus("rst.req", 1, 1, 3'd7, 8'h00, 0, 8'h00, 3'd7, 3'd0);
    idleCycle("rst.wait", 3'd7, 3'd0);
    doReset();
    applyStimulus("rst.after", 0, 0, 3'd0, 8'h00, 1, 8'h55, 3'd7, 3'd4);
    idleCycle("rst.after2", 3'd7, 3'd4);
    checkOutput("rst.reg7", ReadData1, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic       rw, mtr, mv;
      logic [2:0] wr, r1, r2;
      logic [7:0] alu, md;
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        rw  = ($urandom_range(0, 3) != 0);
        mtr = ($urandom_range(0, 2) == 0);
        mv  = ($urandom_range(0, 6) == 0);
        wr  = 3'($urandom);
        r1  = 3'($urandom);
        r2  = 3'($urandom);
        alu = 8'($urandom);
        md  = 8'($urandom);
        applyStimulus("rand", rw, mtr, wr, alu, mv, md, r1, r2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
